// File: rtl/instr_tlb_sa_pkg.sv
// Shared configuration and types for the set-associative instruction TLB.
package instr_tlb_sa_pkg;

    localparam int CFG_VADDR_WIDTH = 32;
    localparam int CFG_PADDR_WIDTH = 32;
    localparam int CFG_PAGE_SHIFT  = 12;
    localparam int CFG_ASID_WIDTH  = 8;
    localparam int CFG_ITLB_SETS   = 4;
    localparam int CFG_ITLB_ASSOC  = 2;
    localparam int CFG_VPN_W       = CFG_VADDR_WIDTH - CFG_PAGE_SHIFT;
    localparam int CFG_PPN_W       = CFG_PADDR_WIDTH - CFG_PAGE_SHIFT;

    // One translation entry; is_global entries match any ASID.
    typedef struct packed {
        logic                      valid;
        logic                      is_global;
        logic                      exec;
        logic                      user;
        logic [CFG_ASID_WIDTH-1:0] asid;
        logic [CFG_VPN_W-1:0]      vpn;
        logic [CFG_PPN_W-1:0]      ppn;
    } tlb_entry_t;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOOKUP    = 3'd1,
        ST_WALK_REQ  = 3'd2,
        ST_WALK_WAIT = 3'd3,
        ST_FILL_RESP = 3'd4,
        ST_FLUSH     = 3'd5
    } itlb_state_e;

endpackage

// File: rtl/instr_tlb_sa_rr_victim.sv
// Victim way selection for refills: lowest invalid way first, otherwise the
// set's round-robin pointer, which only advances when it is actually used.
module tlb_rr_victim
    import instr_tlb_sa_pkg::*;
#(
    parameter int SETS  = CFG_ITLB_SETS,
    parameter int ASSOC = CFG_ITLB_ASSOC,
    parameter int IDX_W = 2,
    parameter int WAY_W = 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [IDX_W-1:0] i_set_idx,
    input  logic [ASSOC-1:0] i_set_valid,
    input  logic             i_alloc,
    output logic [WAY_W-1:0] o_victim
);

    logic [WAY_W-1:0] rr_ptr [SETS];
    logic             any_free;
    logic [WAY_W-1:0] free_way;

    // Priority-encode the lowest invalid way and pick the victim
    always_comb begin
        any_free = 1'b0;
        free_way = '0;
        for (int w = ASSOC - 1; w >= 0; w--) begin
            if (!i_set_valid[w]) begin
                any_free = 1'b1;
                free_way = WAY_W'(w);
            end
        end
        o_victim = any_free ? free_way : rr_ptr[i_set_idx];
    end

    // Advance the set's pointer only when a full set is refilled
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int s = 0; s < SETS; s++) begin
                rr_ptr[s] <= '0;
            end
        end else if (i_alloc && !any_free) begin
            if (rr_ptr[i_set_idx] == WAY_W'(ASSOC - 1)) begin
                rr_ptr[i_set_idx] <= '0;
            end else begin
                rr_ptr[i_set_idx] <= rr_ptr[i_set_idx] + WAY_W'(1);
            end
        end
    end

endmodule

// File: rtl/instr_tlb_sa.sv
// Set-associative instruction TLB: one lookup at a time, blocking miss walk,
// refill with round-robin victim, fault forwarding and per-set flush sweep.
module instr_tlb_sa
    import instr_tlb_sa_pkg::*;
#(
    parameter int VADDR_WIDTH = CFG_VADDR_WIDTH,
    parameter int PADDR_WIDTH = CFG_PADDR_WIDTH,
    parameter int PAGE_SHIFT  = CFG_PAGE_SHIFT,
    parameter int ASID_WIDTH  = CFG_ASID_WIDTH,
    parameter int ITLB_SETS   = CFG_ITLB_SETS,
    parameter int ITLB_ASSOC  = CFG_ITLB_ASSOC,
    localparam int VPN_W = VADDR_WIDTH - PAGE_SHIFT,
    localparam int PPN_W = PADDR_WIDTH - PAGE_SHIFT
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_lookup_valid,
    input  logic [VADDR_WIDTH-1:0] i_vaddr,
    input  logic [ASID_WIDTH-1:0]  i_asid,
    output logic                   o_ready,
    output logic                   o_resp_valid,
    output logic [PADDR_WIDTH-1:0] o_paddr,
    output logic                   o_exec,
    output logic                   o_user,
    output logic                   o_fault,
    output logic                   o_walk_req_valid,
    output logic [VPN_W-1:0]       o_walk_vpn,
    output logic [ASID_WIDTH-1:0]  o_walk_asid,
    input  logic                   i_walk_req_ready,
    input  logic                   i_fill_valid,
    input  logic [PPN_W-1:0]       i_fill_ppn,
    input  logic                   i_fill_exec,
    input  logic                   i_fill_user,
    input  logic                   i_fill_global,
    input  logic                   i_fill_fault,
    input  logic                   i_flush_valid,
    input  logic                   i_flush_asid_only,
    input  logic [ASID_WIDTH-1:0]  i_flush_asid,
    output logic                   o_flush_done
);

    localparam int IDX_W = (ITLB_SETS > 1) ? $clog2(ITLB_SETS) : 1;
    localparam int WAY_W = (ITLB_ASSOC > 1) ? $clog2(ITLB_ASSOC) : 1;

    itlb_state_e state, state_nxt;

    tlb_entry_t entries [ITLB_SETS][ITLB_ASSOC];

    // Accepted request (p0) and response-stage registers (p1)
    logic [VADDR_WIDTH-1:0] vaddr_p0;
    logic [ASID_WIDTH-1:0]  asid_p0;
    logic                   flush_asid_only_p0;
    logic [ASID_WIDTH-1:0]  flush_asid_p0;
    logic [IDX_W-1:0]       flush_idx;
    logic                   hit_vld_p1;
    logic [PADDR_WIDTH-1:0] hit_paddr_p1;
    logic                   hit_exec_p1;
    logic                   hit_user_p1;
    logic [PPN_W-1:0]       fill_ppn_p1;
    logic                   fill_exec_p1;
    logic                   fill_user_p1;
    logic                   fill_fault_p1;

    logic [VPN_W-1:0]       vpn_p0;
    logic [IDX_W-1:0]       set_idx;
    logic [ITLB_ASSOC-1:0]  set_valid;
    logic                   hit;
    tlb_entry_t             hit_entry;
    logic                   fill_we;
    logic                   flush_last;
    logic [WAY_W-1:0]       victim;

    assign vpn_p0     = vaddr_p0[VADDR_WIDTH-1:PAGE_SHIFT];
    assign set_idx    = vpn_p0[IDX_W-1:0] & IDX_W'(ITLB_SETS - 1);
    assign fill_we    = (state == ST_WALK_WAIT) && i_fill_valid && !i_fill_fault;
    assign flush_last = (flush_idx == IDX_W'(ITLB_SETS - 1));

    // Tag compare across the indexed set; lowest matching way wins
    always_comb begin
        hit       = 1'b0;
        hit_entry = '0;
        set_valid = '0;
        for (int w = ITLB_ASSOC - 1; w >= 0; w--) begin
            set_valid[w] = entries[set_idx][w].valid;
            if (entries[set_idx][w].valid && (entries[set_idx][w].vpn == vpn_p0) &&
                (entries[set_idx][w].is_global || (entries[set_idx][w].asid == asid_p0))) begin
                hit       = 1'b1;
                hit_entry = entries[set_idx][w];
            end
        end
    end

    tlb_rr_victim #(
        .SETS  (ITLB_SETS),
        .ASSOC (ITLB_ASSOC),
        .IDX_W (IDX_W),
        .WAY_W (WAY_W)
    ) u_victim (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_set_idx   (set_idx),
        .i_set_valid (set_valid),
        .i_alloc     (fill_we),
        .o_victim    (victim)
    );

    // Next-state and output decode
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: begin
                if (i_flush_valid)       state_nxt = ST_FLUSH;
                else if (i_lookup_valid) state_nxt = ST_LOOKUP;
            end
            ST_LOOKUP:    state_nxt = hit ? ST_IDLE : ST_WALK_REQ;
            ST_WALK_REQ:  if (i_walk_req_ready) state_nxt = ST_WALK_WAIT;
            ST_WALK_WAIT: if (i_fill_valid) state_nxt = ST_FILL_RESP;
            ST_FILL_RESP: state_nxt = ST_IDLE;
            ST_FLUSH:     if (flush_last) state_nxt = ST_IDLE;
            default:      state_nxt = ST_IDLE;
        endcase

        o_ready          = (state == ST_IDLE);
        o_walk_req_valid = (state == ST_WALK_REQ);
        o_walk_vpn       = o_walk_req_valid ? vpn_p0 : '0;
        o_walk_asid      = o_walk_req_valid ? asid_p0 : '0;
        o_flush_done     = (state == ST_FLUSH) && flush_last;
        o_resp_valid     = hit_vld_p1 || (state == ST_FILL_RESP);
        o_paddr          = '0;
        o_exec           = 1'b0;
        o_user           = 1'b0;
        o_fault          = 1'b0;
        if (state == ST_FILL_RESP) begin
            o_fault = fill_fault_p1;
            if (!fill_fault_p1) begin
                o_paddr = {fill_ppn_p1, vaddr_p0[PAGE_SHIFT-1:0]};
                o_exec  = fill_exec_p1;
                o_user  = fill_user_p1;
            end
        end else if (hit_vld_p1) begin
            o_paddr = hit_paddr_p1;
            o_exec  = hit_exec_p1;
            o_user  = hit_user_p1;
        end
    end

    // Control state: FSM, flush sweep index, hit response strobe
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state      <= ST_IDLE;
            flush_idx  <= '0;
            hit_vld_p1 <= 1'b0;
        end else begin
            state      <= state_nxt;
            hit_vld_p1 <= (state == ST_LOOKUP) && hit;
            flush_idx  <= (state == ST_FLUSH) ? flush_idx + IDX_W'(1) : '0;
        end
    end

    // Stage p0 -> p1: request capture, hit data and fill data (no reset)
    always_ff @(posedge i_clk) begin
        if ((state == ST_IDLE) && !i_flush_valid && i_lookup_valid) begin
            vaddr_p0 <= i_vaddr;
            asid_p0  <= i_asid;
        end
        if ((state == ST_IDLE) && i_flush_valid) begin
            flush_asid_only_p0 <= i_flush_asid_only;
            flush_asid_p0      <= i_flush_asid;
        end
        if (state == ST_LOOKUP) begin
            hit_paddr_p1 <= {hit_entry.ppn, vaddr_p0[PAGE_SHIFT-1:0]};
            hit_exec_p1  <= hit_entry.exec;
            hit_user_p1  <= hit_entry.user;
        end
        if ((state == ST_WALK_WAIT) && i_fill_valid) begin
            fill_ppn_p1   <= i_fill_ppn;
            fill_exec_p1  <= i_fill_exec;
            fill_user_p1  <= i_fill_user;
            fill_fault_p1 <= i_fill_fault;
        end
    end

    // Entry array: valid bits reset; refill writes the victim; flush clears one set per cycle
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int s = 0; s < ITLB_SETS; s++) begin
                for (int w = 0; w < ITLB_ASSOC; w++) begin
                    entries[s][w].valid <= 1'b0;
                end
            end
        end else if (fill_we) begin
            entries[set_idx][victim] <= '{valid:     1'b1,
                                          is_global: i_fill_global,
                                          exec:      i_fill_exec,
                                          user:      i_fill_user,
                                          asid:      asid_p0,
                                          vpn:       vpn_p0,
                                          ppn:       i_fill_ppn};
        end else if (state == ST_FLUSH) begin
            for (int w = 0; w < ITLB_ASSOC; w++) begin
                if (!flush_asid_only_p0 ||
                    (!entries[flush_idx][w].is_global && (entries[flush_idx][w].asid == flush_asid_p0))) begin
                    entries[flush_idx][w].valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_instr_tlb_sa.sv
// Testbench for instr_tlb_sa: scenario tasks plus randomized traffic against
// a behavioural model of the TLB contents (4 sets x 2 ways, 4 KiB pages).
module tb_instr_tlb_sa;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_lookup_valid = 1'b0;
    logic [31:0] i_vaddr = '0;
    logic [7:0]  i_asid = '0;
    logic        o_ready, o_resp_valid, o_exec, o_user, o_fault;
    logic [31:0] o_paddr;
    logic        o_walk_req_valid;
    logic [19:0] o_walk_vpn;
    logic [7:0]  o_walk_asid;
    logic        i_walk_req_ready = 1'b0;
    logic        i_fill_valid = 1'b0;
    logic [19:0] i_fill_ppn = '0;
    logic        i_fill_exec = 1'b0, i_fill_user = 1'b0, i_fill_global = 1'b0, i_fill_fault = 1'b0;
    logic        i_flush_valid = 1'b0, i_flush_asid_only = 1'b0;
    logic [7:0]  i_flush_asid = '0;
    logic        o_flush_done;

    int total = 0;
    int bad   = 0;

    // Model of the TLB: what is cached where, and each set's replacement pointer
    bit        m_valid [4][2];
    bit [19:0] m_vpn   [4][2];
    bit [19:0] m_ppn   [4][2];
    bit [7:0]  m_asid  [4][2];
    bit        m_glob  [4][2];
    bit        m_exec  [4][2];
    bit        m_user  [4][2];
    int        m_rr    [4];

    instr_tlb_sa dut (
        .i_clk             (i_clk),
        .i_rst             (i_rst),
        .i_lookup_valid    (i_lookup_valid),
        .i_vaddr           (i_vaddr),
        .i_asid            (i_asid),
        .o_ready           (o_ready),
        .o_resp_valid      (o_resp_valid),
        .o_paddr           (o_paddr),
        .o_exec            (o_exec),
        .o_user            (o_user),
        .o_fault           (o_fault),
        .o_walk_req_valid  (o_walk_req_valid),
        .o_walk_vpn        (o_walk_vpn),
        .o_walk_asid       (o_walk_asid),
        .i_walk_req_ready  (i_walk_req_ready),
        .i_fill_valid      (i_fill_valid),
        .i_fill_ppn        (i_fill_ppn),
        .i_fill_exec       (i_fill_exec),
        .i_fill_user       (i_fill_user),
        .i_fill_global     (i_fill_global),
        .i_fill_fault      (i_fill_fault),
        .i_flush_valid     (i_flush_valid),
        .i_flush_asid_only (i_flush_asid_only),
        .i_flush_asid      (i_flush_asid),
        .o_flush_done      (o_flush_done)
    );

    always #5 i_clk = ~i_clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    function automatic void model_reset();
        for (int s = 0; s < 4; s++) begin
            m_rr[s] = 0;
            for (int w = 0; w < 2; w++) m_valid[s][w] = 0;
        end
    endfunction

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic test_reset();
        i_rst = 1'b1;
        step();
        step();
        model_reset();
        total++; if (o_ready !== 1'b1) begin bad++; $display("FAIL reset_ready act=%0b exp=1", o_ready); end
        total++; if (o_resp_valid !== 1'b0) begin bad++; $display("FAIL reset_resp act=%0b exp=0", o_resp_valid); end
        total++; if (o_walk_req_valid !== 1'b0) begin bad++; $display("FAIL reset_walk act=%0b exp=0", o_walk_req_valid); end
        total++; if (o_flush_done !== 1'b0) begin bad++; $display("FAIL reset_flush_done act=%0b exp=0", o_flush_done); end
        total++; if (o_paddr !== 32'h0 || o_fault !== 1'b0) begin bad++; $display("FAIL reset_paddr act=%h/%0b exp=0/0", o_paddr, o_fault); end
        i_rst = 1'b0;
        step();
    endtask

    // One lookup; the model decides hit or miss, a miss is walked and filled.
    // Starts and ends with the DUT idle, sampling 1 time unit after a clock edge.
    task automatic do_lookup(input logic [31:0] va, input logic [7:0] asid, input logic [19:0] fppn,
                             input bit fglob, input bit fexec, input bit fuser, input bit ffault,
                             input int req_stall, input int fill_delay);
        logic [19:0] vpn;
        logic [31:0] exp_pa;
        int          set, hw, vw;
        bit          hit;
        vpn = va[31:12];
        set = int'(vpn[1:0]);
        hit = 0;
        hw  = 0;
        for (int w = 1; w >= 0; w--) begin
            if (m_valid[set][w] && m_vpn[set][w] == vpn && (m_glob[set][w] || m_asid[set][w] == asid)) begin
                hit = 1;
                hw  = w;
            end
        end
        total++; if (o_ready !== 1'b1) begin bad++; $display("FAIL lk_ready va=%h act=%0b exp=1", va, o_ready); end
        i_lookup_valid = 1'b1;
        i_vaddr        = va;
        i_asid         = asid;
        step();
        i_lookup_valid = 1'b0;
        i_vaddr        = $urandom;
        total++; if (o_resp_valid !== 1'b0) begin bad++; $display("FAIL lk_early_resp va=%h act=%0b exp=0", va, o_resp_valid); end
        step();
        if (hit) begin
            exp_pa = {m_ppn[set][hw], va[11:0]};
            total++; if (o_resp_valid !== 1'b1) begin bad++; $display("FAIL hit_resp va=%h act=%0b exp=1", va, o_resp_valid); end
            total++; if (o_paddr !== exp_pa) begin bad++; $display("FAIL hit_paddr va=%h act=%h exp=%h", va, o_paddr, exp_pa); end
            total++; if (o_exec !== m_exec[set][hw] || o_user !== m_user[set][hw] || o_fault !== 1'b0) begin
                bad++; $display("FAIL hit_flags va=%h act=%0b%0b%0b exp=%0b%0b0", va, o_exec, o_user, o_fault, m_exec[set][hw], m_user[set][hw]);
            end
            total++; if (o_walk_req_valid !== 1'b0) begin bad++; $display("FAIL hit_no_walk va=%h act=%0b exp=0", va, o_walk_req_valid); end
        end else begin
            total++; if (o_walk_req_valid !== 1'b1 || o_walk_vpn !== vpn || o_walk_asid !== asid) begin
                bad++; $display("FAIL miss_walk va=%h act=%0b/%h/%h exp=1/%h/%h", va, o_walk_req_valid, o_walk_vpn, o_walk_asid, vpn, asid);
            end
            total++; if (o_resp_valid !== 1'b0) begin bad++; $display("FAIL miss_no_resp va=%h act=%0b exp=0", va, o_resp_valid); end
            for (int i = 0; i < req_stall; i++) begin
                i_fill_valid = 1'b1;
                i_fill_ppn   = ~fppn;
                step();
                total++; if (o_walk_req_valid !== 1'b1 || o_walk_vpn !== vpn) begin
                    bad++; $display("FAIL walk_hold va=%h act=%0b/%h exp=1/%h", va, o_walk_req_valid, o_walk_vpn, vpn);
                end
            end
            i_fill_valid     = 1'b0;
            i_walk_req_ready = 1'b1;
            step();
            i_walk_req_ready = 1'b0;
            total++; if (o_walk_req_valid !== 1'b0) begin bad++; $display("FAIL walk_drop va=%h act=%0b exp=0", va, o_walk_req_valid); end
            for (int i = 0; i < fill_delay; i++) begin
                step();
                total++; if (o_resp_valid !== 1'b0) begin bad++; $display("FAIL wait_no_resp va=%h act=%0b exp=0", va, o_resp_valid); end
            end
            i_fill_valid  = 1'b1;
            i_fill_ppn    = fppn;
            i_fill_exec   = fexec;
            i_fill_user   = fuser;
            i_fill_global = fglob;
            i_fill_fault  = ffault;
            step();
            i_fill_valid  = 1'b0;
            i_fill_fault  = 1'b0;
            exp_pa = ffault ? 32'h0 : {fppn, va[11:0]};
            total++; if (o_resp_valid !== 1'b1 || o_fault !== ffault) begin
                bad++; $display("FAIL fill_resp va=%h act=%0b/%0b exp=1/%0b", va, o_resp_valid, o_fault, ffault);
            end
            total++; if (o_paddr !== exp_pa) begin bad++; $display("FAIL fill_paddr va=%h act=%h exp=%h", va, o_paddr, exp_pa); end
            if (!ffault) begin
                total++; if (o_exec !== fexec || o_user !== fuser) begin
                    bad++; $display("FAIL fill_flags va=%h act=%0b%0b exp=%0b%0b", va, o_exec, o_user, fexec, fuser);
                end
                if (!m_valid[set][0])      vw = 0;
                else if (!m_valid[set][1]) vw = 1;
                else begin
                    vw = m_rr[set];
                    m_rr[set] = (m_rr[set] + 1) % 2;
                end
                m_valid[set][vw] = 1;
                m_vpn[set][vw]   = vpn;
                m_ppn[set][vw]   = fppn;
                m_asid[set][vw]  = asid;
                m_glob[set][vw]  = fglob;
                m_exec[set][vw]  = fexec;
                m_user[set][vw]  = fuser;
            end
            step();
            total++; if (o_resp_valid !== 1'b0) begin bad++; $display("FAIL resp_pulse va=%h act=%0b exp=0", va, o_resp_valid); end
        end
        total++; if (o_ready !== 1'b1) begin bad++; $display("FAIL back_idle va=%h act=%0b exp=1", va, o_ready); end
    endtask

    // Flush request, optionally with a competing lookup that must be refused
    task automatic do_flush(input bit asid_only, input logic [7:0] fasid, input bit with_lookup);
        total++; if (o_ready !== 1'b1) begin bad++; $display("FAIL flush_ready act=%0b exp=1", o_ready); end
        i_flush_valid     = 1'b1;
        i_flush_asid_only = asid_only;
        i_flush_asid      = fasid;
        i_lookup_valid    = with_lookup;
        i_vaddr           = 32'h0000_1abc;
        i_asid            = 8'd3;
        step();
        i_flush_valid  = 1'b0;
        i_lookup_valid = 1'b0;
        i_flush_asid   = ~fasid;
        for (int c = 1; c <= 4; c++) begin
            total++; if (o_flush_done !== (c == 4)) begin bad++; $display("FAIL flush_done_cycle c=%0d act=%0b exp=%0b", c, o_flush_done, (c == 4)); end
            total++; if (o_ready !== 1'b0 || o_resp_valid !== 1'b0) begin
                bad++; $display("FAIL flush_busy c=%0d act=%0b/%0b exp=0/0", c, o_ready, o_resp_valid);
            end
            step();
        end
        total++; if (o_flush_done !== 1'b0 || o_ready !== 1'b1) begin bad++; $display("FAIL flush_end act=%0b/%0b exp=0/1", o_flush_done, o_ready); end
        total++; if (o_walk_req_valid !== 1'b0 || o_resp_valid !== 1'b0) begin
            bad++; $display("FAIL flush_lookup_dropped act=%0b/%0b exp=0/0", o_walk_req_valid, o_resp_valid);
        end
        for (int s = 0; s < 4; s++)
            for (int w = 0; w < 2; w++)
                if (!asid_only || (!m_glob[s][w] && m_asid[s][w] == fasid)) m_valid[s][w] = 0;
    endtask

    task automatic test_cold_miss_and_hit();
        do_lookup(32'h0000_1234, 8'd3, 20'h00080, 0, 1, 0, 0, 1, 1);
        do_lookup(32'h0000_1234, 8'd3, 20'h00000, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_eviction();
        do_lookup(32'h0000_5010, 8'd3, 20'h00055, 0, 1, 1, 0, 0, 0);
        do_lookup(32'h0000_9020, 8'd3, 20'h00099, 0, 0, 1, 0, 2, 0);
        do_lookup(32'h0000_9ffc, 8'd3, 20'h0, 0, 0, 0, 0, 0, 0);
        do_lookup(32'h0000_1234, 8'd3, 20'h00081, 0, 1, 0, 0, 0, 2);
        do_lookup(32'h0000_5444, 8'd3, 20'h00056, 0, 1, 0, 0, 0, 0);
    endtask

    task automatic test_asid_flush();
        test_reset();
        do_lookup(32'h0001_0100, 8'd3, 20'h00a10, 0, 1, 0, 0, 0, 0);
        do_lookup(32'h0002_1200, 8'd3, 20'h00a21, 1, 1, 1, 0, 0, 0);
        do_lookup(32'h0003_2300, 8'd4, 20'h00a32, 0, 0, 1, 0, 0, 0);
        do_flush(1, 8'd3, 0);
        do_lookup(32'h0002_1204, 8'd3, 20'h0, 0, 0, 0, 0, 0, 0);
        do_lookup(32'h0003_2308, 8'd4, 20'h0, 0, 0, 0, 0, 0, 0);
        do_lookup(32'h0001_0104, 8'd3, 20'h00b10, 0, 1, 0, 0, 0, 0);
    endtask

    task automatic test_fault();
        do_lookup(32'h0000_7abc, 8'd3, 20'h00777, 0, 1, 1, 1, 0, 1);
        do_lookup(32'h0000_7abc, 8'd3, 20'h00778, 0, 1, 1, 0, 1, 0);
        do_lookup(32'h0000_7000, 8'd3, 20'h0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_flush_priority();
        do_flush(0, 8'd0, 1);
        do_lookup(32'h0000_1abc, 8'd3, 20'h00c01, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_reset_midwalk();
        i_lookup_valid = 1'b1;
        i_vaddr        = 32'h0000_3abc;
        i_asid         = 8'd5;
        step();
        i_lookup_valid = 1'b0;
        step();
        i_walk_req_ready = 1'b1;
        step();
        i_walk_req_ready = 1'b0;
        total++; if (o_walk_req_valid !== 1'b0 || o_ready !== 1'b0) begin
            bad++; $display("FAIL midwalk_wait act=%0b/%0b exp=0/0", o_walk_req_valid, o_ready);
        end
        i_rst = 1'b1;
        step();
        i_rst = 1'b0;
        model_reset();
        total++; if (o_walk_req_valid !== 1'b0 || o_ready !== 1'b1 || o_resp_valid !== 1'b0) begin
            bad++; $display("FAIL midwalk_reset act=%0b/%0b/%0b exp=0/1/0", o_walk_req_valid, o_ready, o_resp_valid);
        end
        i_fill_valid = 1'b1;
        i_fill_ppn   = 20'h00333;
        step();
        i_fill_valid = 1'b0;
        total++; if (o_resp_valid !== 1'b0 || o_ready !== 1'b1) begin
            bad++; $display("FAIL late_fill act=%0b/%0b exp=0/1", o_resp_valid, o_ready);
        end
        do_lookup(32'h0000_3abc, 8'd5, 20'h00334, 0, 1, 1, 0, 0, 0);
    endtask

    task automatic test_random();
        for (int n = 0; n < 80; n++) begin
            if ($urandom_range(0, 9) == 0) begin
                do_flush(1'($urandom_range(0, 1)), 8'($urandom_range(3, 4)), 0);
            end else begin
                do_lookup({12'h0, 4'($urandom_range(0, 11)), 4'h0, 12'($urandom)}, 8'($urandom_range(3, 4)),
                          20'($urandom), ($urandom_range(0, 3) == 0), 1'($urandom), 1'($urandom),
                          ($urandom_range(0, 7) == 0), $urandom_range(0, 2), $urandom_range(0, 2));
            end
        end
    endtask

    initial begin
        test_reset();
        test_cold_miss_and_hit();
        test_eviction();
        test_asid_flush();
        test_fault();
        test_flush_priority();
        test_reset_midwalk();
        test_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
